// File: rtl/hd_pair_sched.sv
// Two-port Hamming(7,4) pair decoder: round-robin grant, one shared syndrome unit
// used over two cycles, signed pair combine and a saturating corrected-word counter.
module hd_pair_sched #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [6:0]       req0_cw1,
    input  logic [6:0]       req0_cw2,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [6:0]       req1_cw1,
    input  logic [6:0]       req1_cw2,
    output logic             req1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_n,
    output logic             out_id,
    output logic [1:0]       out_err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, DEC1, DEC2, OUT} state_t;

    state_t           state_q;
    logic [6:0]       cw1_q, cw2_q;
    logic             id_q;
    logic             ptr_q;
    logic [3:0]       c1_q;
    logic             f1_q;
    logic             out_valid_q;
    logic [5:0]       out_n_q;
    logic             out_id_q;
    logic [1:0]       out_err_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       grant_id;
    logic       accept;
    logic [6:0] dec_cw;
    logic [2:0] dec_syn;
    logic [6:0] dec_flip;
    logic [3:0] dec_c;
    logic       dec_f;
    logic       dec_err;
    logic [5:0] c1_x, c2_x, comb_n;

    // Both valid: serve the requester the pointer favours; otherwise whoever is valid.
    always_comb begin
        grant_id   = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        accept     = (state_q == IDLE) && (req0_valid || req1_valid);
        req0_ready = (state_q == IDLE) && req0_valid && !grant_id;
        req1_ready = (state_q == IDLE) && req1_valid && grant_id;
    end

    always_comb begin
        dec_cw  = (state_q == DEC2) ? cw2_q : cw1_q;
        dec_syn = {dec_cw[6] ^ dec_cw[3] ^ dec_cw[2] ^ dec_cw[1],
                   dec_cw[5] ^ dec_cw[3] ^ dec_cw[2] ^ dec_cw[0],
                   dec_cw[4] ^ dec_cw[3] ^ dec_cw[1] ^ dec_cw[0]};
        case (dec_syn)
            3'b011:  dec_flip = 7'b000_0001;
            3'b101:  dec_flip = 7'b000_0010;
            3'b110:  dec_flip = 7'b000_0100;
            3'b111:  dec_flip = 7'b000_1000;
            3'b001:  dec_flip = 7'b001_0000;
            3'b010:  dec_flip = 7'b010_0000;
            3'b100:  dec_flip = 7'b100_0000;
            default: dec_flip = '0;
        endcase
        dec_c   = dec_cw[3:0] ^ dec_flip[3:0];
        dec_f   = (dec_syn == 3'b000) ? dec_cw[0] : |(dec_cw & dec_flip);
        dec_err = |dec_syn;
    end

    // Modulo-64 arithmetic on sign-extended operands yields the exact signed result.
    always_comb begin
        c1_x = {{2{c1_q[3]}}, c1_q};
        c2_x = {{2{dec_c[3]}}, dec_c};
        case ({f1_q, dec_f})
            2'b00:   comb_n = c1_x + c1_x + c2_x;
            2'b01:   comb_n = c1_x + c1_x - c2_x;
            2'b10:   comb_n = c1_x - c2_x - c2_x;
            default: comb_n = c1_x + c2_x + c2_x;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if ((state_q == DEC1 || state_q == DEC2) && dec_err && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cw1_q       <= '0;
            cw2_q       <= '0;
            id_q        <= 1'b0;
            ptr_q       <= 1'b0;
            c1_q        <= '0;
            f1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_n_q     <= '0;
            out_id_q    <= 1'b0;
            out_err_q   <= '0;
            cnt_q       <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cw1_q   <= grant_id ? req1_cw1 : req0_cw1;
                        cw2_q   <= grant_id ? req1_cw2 : req0_cw2;
                        id_q    <= grant_id;
                        ptr_q   <= ~grant_id;
                        state_q <= DEC1;
                    end
                end
                DEC1: begin
                    c1_q         <= dec_c;
                    f1_q         <= dec_f;
                    out_err_q[1] <= dec_err;
                    state_q      <= DEC2;
                end
                DEC2: begin
                    out_n_q      <= comb_n;
                    out_id_q     <= id_q;
                    out_err_q[0] <= dec_err;
                    out_valid_q  <= 1'b1;
                    state_q      <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_n     = out_n_q;
    assign out_id    = out_id_q;
    assign out_err   = out_err_q;
    assign err_cnt   = cnt_q;

endmodule
